// File: rtl/mult_pipe.sv
// -----------------------------------------------------------------------------
// mult_pipe
//   Fully pipelined RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU).
//   The unit decodes the op itself, extends both operands to 2*XLEN, and
//   retires K = 2*XLEN/NUM_STAGE multiplier bits per stage as a shift-and-add
//   digit step. Every stage has its own valid bit and loads whenever it is
//   empty or is handing its contents downstream, so bubbles collapse and a
//   stalled tail never blocks empty upstream stages. An opaque tag travels
//   with each op, and a global flush squashes everything in flight.
//
// Parameters
//   XLEN       operand / result width
//   NUM_STAGE  pipeline register stages; (2*XLEN) % NUM_STAGE must be 0
//   TAG_W      width of the opaque tag
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-low reset
//   in_valid    issue presents an op
//   in_ready    unit accepts an op this cycle (combinational on out_ready/flush)
//   in_op       0=MUL 1=MULH 2=MULHSU 3=MULHU (funct3[1:0])
//   in_rs1      multiplicand
//   in_rs2      multiplier
//   in_tag      opaque tag
//   flush       squash every in-flight op
//   out_valid   result available
//   out_ready   complete stage takes the result
//   out_result  selected product half
//   out_tag     tag belonging to out_result
//
// Optional feature (macro MULT_PIPE_PERF_EN)
//   perf_ops     32-bit count of delivered results (out_valid & out_ready)
//   perf_stalls  32-bit count of cycles with out_valid & !out_ready
//   Both wrap, reset to 0 and are not affected by flush.
// -----------------------------------------------------------------------------
module mult_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_STAGE = 4,
    parameter int unsigned TAG_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
`ifdef MULT_PIPE_PERF_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_stalls
`endif
);

    localparam int unsigned PW   = 2 * XLEN;
    localparam int unsigned K    = PW / NUM_STAGE;
    localparam int unsigned LAST = NUM_STAGE - 1;

    if ((PW % NUM_STAGE) != 0) begin : g_bad_cfg
        $error("mult_pipe: (2*XLEN) must be a multiple of NUM_STAGE");
    end

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } op_e;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic [PW-1:0]        r_prod   [NUM_STAGE];
    logic [PW-1:0]        r_mcand  [NUM_STAGE];
    logic [PW-1:0]        r_mplier [NUM_STAGE];
    op_e                  r_op     [NUM_STAGE];
    logic [TAG_W-1:0]     r_tag    [NUM_STAGE];
    logic [NUM_STAGE-1:0] r_valid;

    // ------------------------------------------------------------------
    // Per-stage sources (what stage i would load) and next-state values
    // ------------------------------------------------------------------
    logic [PW-1:0]        w_src_prod   [NUM_STAGE];
    logic [PW-1:0]        w_src_mcand  [NUM_STAGE];
    logic [PW-1:0]        w_src_mplier [NUM_STAGE];
    op_e                  w_src_op     [NUM_STAGE];
    logic [TAG_W-1:0]     w_src_tag    [NUM_STAGE];
    logic [NUM_STAGE-1:0] w_src_valid;

    logic [PW-1:0]        w_nxt_prod   [NUM_STAGE];
    logic [PW-1:0]        w_nxt_mcand  [NUM_STAGE];
    logic [PW-1:0]        w_nxt_mplier [NUM_STAGE];

    logic [NUM_STAGE-1:0] w_take;
    logic                 w_accept;
    op_e                  w_in_op;
    logic                 w_rs1_sx;
    logic                 w_rs2_sx;
    logic [PW-1:0]        w_ext_rs1;
    logic [PW-1:0]        w_ext_rs2;

    // ------------------------------------------------------------------
    // Entry decode: signedness comes from the op, not from the caller
    // ------------------------------------------------------------------
    assign w_in_op   = op_e'(in_op);
    assign w_rs1_sx  = (w_in_op == OP_MULH) || (w_in_op == OP_MULHSU);
    assign w_rs2_sx  = (w_in_op == OP_MULH);
    assign w_ext_rs1 = {{XLEN{w_rs1_sx & in_rs1[XLEN-1]}}, in_rs1};
    assign w_ext_rs2 = {{XLEN{w_rs2_sx & in_rs2[XLEN-1]}}, in_rs2};

    // ------------------------------------------------------------------
    // Advance chain: a stage may load when it is empty or when its current
    // contents move on this cycle. Evaluated from the tail backwards so the
    // last stage's drain (out_ready) ripples up to in_ready.
    // ------------------------------------------------------------------
    always_comb begin
        w_take       = '0;
        w_take[LAST] = !r_valid[LAST] || out_ready;
        for (int unsigned i = LAST; i > 0; i--) begin
            w_take[i-1] = !r_valid[i-1] || w_take[i];
        end
    end

    assign in_ready = w_take[0] && !flush;
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Source selection: stage 0 from the issue port, others from upstream
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_STAGE; g++) begin : g_src
        if (g == 0) begin : g_head
            assign w_src_prod[g]   = '0;
            assign w_src_mcand[g]  = w_ext_rs1;
            assign w_src_mplier[g] = w_ext_rs2;
            assign w_src_op[g]     = w_in_op;
            assign w_src_tag[g]    = in_tag;
            assign w_src_valid[g]  = w_accept;
        end else begin : g_body
            assign w_src_prod[g]   = r_prod[g-1];
            assign w_src_mcand[g]  = r_mcand[g-1];
            assign w_src_mplier[g] = r_mplier[g-1];
            assign w_src_op[g]     = r_op[g-1];
            assign w_src_tag[g]    = r_tag[g-1];
            assign w_src_valid[g]  = r_valid[g-1];
        end
    end

    // ------------------------------------------------------------------
    // Digit step: add mcand times the low K multiplier bits, then shift
    // both operands by K. All arithmetic is modulo 2^(2*XLEN), which is
    // what makes the sign-extended operands yield the signed products.
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < NUM_STAGE; i++) begin
            w_nxt_prod[i]   = w_src_prod[i]
                            + (w_src_mcand[i] * PW'(w_src_mplier[i][K-1:0]));
            w_nxt_mcand[i]  = w_src_mcand[i] << K;
            w_nxt_mplier[i] = w_src_mplier[i] >> K;
        end
    end

    // ------------------------------------------------------------------
    // Stage registers. Flush only drops valid bits; the data is dead once
    // its valid bit is gone, so it is simply left in place.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < NUM_STAGE; i++) begin
                r_prod[i]   <= '0;
                r_mcand[i]  <= '0;
                r_mplier[i] <= '0;
                r_op[i]     <= OP_MUL;
                r_tag[i]    <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_STAGE; i++) begin
                if (w_take[i]) begin
                    r_valid[i] <= w_src_valid[i];
                    // Only real ops overwrite data, so a bubble passing
                    // through leaves the previous contents untouched.
                    if (w_src_valid[i]) begin
                        r_prod[i]   <= w_nxt_prod[i];
                        r_mcand[i]  <= w_nxt_mcand[i];
                        r_mplier[i] <= w_nxt_mplier[i];
                        r_op[i]     <= w_src_op[i];
                        r_tag[i]    <= w_src_tag[i];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output select from the last stage
    // ------------------------------------------------------------------
    assign out_valid  = r_valid[LAST];
    assign out_tag    = r_tag[LAST];
    assign out_result = (r_op[LAST] == OP_MUL) ? r_prod[LAST][XLEN-1:0]
                                               : r_prod[LAST][PW-1:XLEN];

`ifdef MULT_PIPE_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32)
    // ------------------------------------------------------------------
    logic [31:0] r_perf_ops;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_ops    <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (out_valid && out_ready) begin
                r_perf_ops <= r_perf_ops + 32'd1;
            end
            if (out_valid && !out_ready) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_ops    = r_perf_ops;
    assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_mult_pipe
//   Scoreboard bench for mult_pipe (XLEN=32, NUM_STAGE=4, TAG_W=16).
//   Expected results are queued at the moment an op is accepted and popped
//   when the unit delivers a result. Directed cases push hand-derived
//   constants; random traffic uses a 64-bit integer reference product.
//   Inputs change 1 time unit after the rising edge; handshakes and
//   outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_mult_pipe;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NUM_STAGE = 4;
    localparam int unsigned TAG_W     = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
`ifdef MULT_PIPE_PERF_EN
    logic [31:0]      perf_ops;
    logic [31:0]      perf_stalls;
`endif

    mult_pipe #(
        .XLEN      (XLEN),
        .NUM_STAGE (NUM_STAGE),
        .TAG_W     (TAG_W)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
`ifdef MULT_PIPE_PERF_EN
        ,
        .perf_ops   (perf_ops),
        .perf_stalls(perf_stalls)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  res;
    } exp_t;

    exp_t            sb[$];
    logic [XLEN-1:0] exp_next;
    int unsigned     n_vec;
    int unsigned     n_err;
    int unsigned     cyc;
    int unsigned     n_acc;
    int unsigned     n_del;
    int unsigned     n_stall;

    task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          ps;
        longint unsigned pu;
        logic [63:0]     p;
        case (op)
            2'd1:    ps = longint'($signed(a)) * longint'($signed(b));
            2'd2:    ps = longint'($signed(a)) * longint'(b);
            default: ps = 0;
        endcase
        pu = longint'(a) * longint'(b);
        p  = (op == 2'd1 || op == 2'd2) ? 64'(ps) : 64'(pu);
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // One clock: observe handshakes on the falling edge, then advance.
    task automatic step();
        exp_t e;
        @(negedge clock);
        if (in_valid && in_ready) begin
            sb.push_back('{tag: in_tag, res: exp_next});
            n_acc++;
        end
        if (out_valid && !out_ready) n_stall++;
        if (out_valid && out_ready) begin
            n_del++;
            if (sb.size() == 0) begin
                check_eq("spurious_out", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check_eq("out_tag", 64'(out_tag), 64'(e.tag));
                check_eq("out_result", 64'(out_result), 64'(e.res));
            end
        end
        if (flush) sb.delete();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] expv);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        exp_next = expv;
    endtask

    task automatic idle(input int unsigned n);
        in_valid = 1'b0;
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic drive_rand(input logic [TAG_W-1:0] tag);
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        op = 2'($urandom_range(0, 3));
        a  = pick_operand();
        b  = pick_operand();
        drive(op, a, b, tag, ref_mul(op, a, b));
    endtask

    // Accept one op and measure edges until it reaches the output.
    task automatic latency_case(input string name, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [TAG_W-1:0] tag,
                                input logic [XLEN-1:0] expv);
        int unsigned s;
        int unsigned acc0;
        out_ready = 1'b1;
        drive(op, a, b, tag, expv);
        s    = cyc;
        acc0 = n_acc;
        step();
        in_valid = 1'b0;
        check_eq({name, "_accepted"}, 64'(n_acc - acc0), 64'd1);
        while (!out_valid && (cyc - s) < 12) step();
        check_eq({name, "_latency"}, 64'(cyc - s), 64'(NUM_STAGE));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got t=%0t, expected finish", $time);
        $fatal(1, "tb_mult_pipe timeout");
    end

    initial begin
        int unsigned      base_acc;
        int unsigned      base_del;
        int unsigned      base_stall;
        int unsigned      s;
        logic [TAG_W-1:0] t;
        logic [XLEN-1:0]  held_res;
        logic [TAG_W-1:0] held_tag;
        logic             held;
`ifdef MULT_PIPE_PERF_EN
        logic [31:0]      base_pops;
        logic [31:0]      base_pstalls;
`endif

        n_vec = 0; n_err = 0; cyc = 0; n_acc = 0; n_del = 0; n_stall = 0;
        reset = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b1; exp_next = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_result", 64'(out_result), 64'd0);
        check_eq("rst_out_tag", 64'(out_tag), 64'd0);
        reset = 1'b1;
        idle(1);

        // ---------------- basic latency ----------------
        latency_case("mul6x7", 2'd0, 32'd6, 32'd7, 16'h0011, 32'd42);

        // ---------------- sign cases, back to back ----------------
        drive(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0101, 32'h0000_0000); step();
        drive(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0103, 32'hFFFF_FFFE); step();
        drive(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0102, 32'hFFFF_FFFF); step();
        drive(2'd0, 32'h8000_0000, 32'h0000_0002, 16'h0100, 32'h0000_0000); step();
        drive(2'd2, 32'h0000_0002, 32'hFFFF_FFFF, 16'h0104, 32'h0000_0001); step();
        drive(2'd1, 32'h8000_0000, 32'h8000_0000, 16'h0105, 32'h4000_0000); step();
        idle(8);
        check_eq("sign_sb_empty", 64'(sb.size()), 64'd0);

        // ---------------- backpressure / capacity ----------------
        base_acc   = n_acc;
        base_stall = n_stall;
`ifdef MULT_PIPE_PERF_EN
        base_pops    = perf_ops;
        base_pstalls = perf_stalls;
`endif
        out_ready = 1'b0;
        held      = 1'b0;
        held_res  = '0;
        held_tag  = '0;
        t = 16'd1;
        for (int unsigned i = 0; i < 8; i++) begin
            drive_rand(t);
            step();
            if (n_acc - base_acc == 32'(t)) t++;
            if (out_valid) begin
                if (!held) begin
                    held     = 1'b1;
                    held_res = out_result;
                    held_tag = out_tag;
                end else begin
                    check_eq("hold_result", 64'(out_result), 64'(held_res));
                    check_eq("hold_tag", 64'(out_tag), 64'(held_tag));
                end
            end
        end
        check_eq("bp_capacity", 64'(n_acc - base_acc), 64'(NUM_STAGE));
        check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
        check_eq("bp_out_valid", 64'(out_valid), 64'd1);
        check_eq("bp_head_tag", 64'(out_tag), 64'd1);

        out_ready = 1'b1;
        base_del  = n_del;
        s         = cyc;
        while ((n_del - base_del) < 6 && (cyc - s) < 20) begin
            if (t <= 16'd6) drive_rand(t);
            else in_valid = 1'b0;
            step();
            if (n_acc - base_acc == 32'(t)) t++;
        end
        in_valid = 1'b0;
        check_eq("bp_drain_cycles", 64'(cyc - s), 64'd6);
        check_eq("bp_delivered", 64'(n_del - base_del), 64'd6);
        check_eq("bp_sb_empty", 64'(sb.size()), 64'd0);
`ifdef MULT_PIPE_PERF_EN
        check_eq("perf_ops", 64'(perf_ops - base_pops), 64'd6);
        check_eq("perf_stalls", 64'(perf_stalls - base_pstalls), 64'(n_stall - base_stall));
`endif
        idle(2);

        // ---------------- flush ----------------
        for (int unsigned k = 1; k <= 3; k++) begin
            drive_rand(TAG_W'(k));
            step();
        end
        drive_rand(16'd4);
        flush    = 1'b1;
        base_acc = n_acc;
        #1;
        check_eq("flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_tag4_rejected", 64'(n_acc - base_acc), 64'd0);
        check_eq("flush_out_valid", 64'(out_valid), 64'd0);
        base_del = n_del;
        idle(8);
        check_eq("flush_no_output", 64'(n_del - base_del), 64'd0);
        latency_case("post_flush", 2'd0, 32'd1234, 32'd1000, 16'h00F0, 32'd1234000);

        // ---------------- asynchronous reset mid-flight ----------------
        out_ready = 1'b0;
        drive_rand(16'h0A01); step();
        drive_rand(16'h0A02); step();
        idle(4);
        check_eq("pre_rst_out_valid", 64'(out_valid), 64'd1);
        reset = 1'b0;
        #1;
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_in_ready", 64'(in_ready), 64'd1);
        check_eq("arst_out_result", 64'(out_result), 64'd0);
        check_eq("arst_out_tag", 64'(out_tag), 64'd0);
        #2;
        reset = 1'b1;
        sb.delete();
        out_ready = 1'b1;
        base_del  = n_del;
        idle(8);
        check_eq("arst_no_output", 64'(n_del - base_del), 64'd0);

        // ---------------- random traffic with random backpressure ----------------
        for (int unsigned i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) != 0) drive_rand(TAG_W'($urandom()));
            else in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        s = cyc;
        while (sb.size() != 0 && (cyc - s) < 20) step();
        idle(2);
        check_eq("rand_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
